// File: rtl/breakout_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// breakout_pkg: constants shared by the VGA, ball and sound blocks.  Rev 1.0
// ---------------------------------------------------------------------------
package breakout_pkg;

  localparam int CLK_FREQ_HZ = 25_000_000;

  localparam logic [1:0] TONE_NONE   = 2'd0;
  localparam logic [1:0] TONE_HIT    = 2'd1;
  localparam logic [1:0] TONE_PADDLE = 2'd2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sound_gen_tone_div.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_div: square-wave divider, toggles every half_period clk cycles.  Rev 1.0
// ---------------------------------------------------------------------------
module tone_div #(
  parameter int HALF_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [HALF_W-1:0] half_period,
  output logic              square
);

  localparam logic [HALF_W-1:0] c_one = HALF_W'(1);

  logic [HALF_W-1:0] r_half_cnt;
  logic              r_square;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_half_cnt <= '0;
      r_square   <= 1'b0;
    end else if (r_half_cnt == (half_period - c_one)) begin
      r_half_cnt <= '0;
      r_square   <= ~r_square;
    end else begin
      r_half_cnt <= r_half_cnt + c_one;
    end
  end

  assign square = r_square;

endmodule
`default_nettype wire

// File: rtl/sound_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sound_gen: turns ball-block sound events into a fixed-length square tone.  Rev 1.0
// ---------------------------------------------------------------------------
module sound_gen
  import breakout_pkg::*;
#(
  parameter int TONE1_HALF = 28409,
  parameter int TONE2_HALF = 14205,
  parameter int DURATION   = 1250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_sound1,
  input  logic       play_sound2,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] tone_sel
);

  localparam int HALF_W = $clog2(max2(TONE1_HALF, TONE2_HALF) + 1);
  localparam int DUR_W  = $clog2(DURATION);

  localparam logic [HALF_W-1:0] c_half1    = HALF_W'(TONE1_HALF);
  localparam logic [HALF_W-1:0] c_half2    = HALF_W'(TONE2_HALF);
  localparam logic [DUR_W-1:0]  c_dur_load = DUR_W'(DURATION - 1);
  localparam logic [DUR_W-1:0]  c_dur_one  = DUR_W'(1);

  logic             r_prev1, r_prev2;
  logic [0:0]       r_state;
  logic [1:0]       r_tone_sel;
  logic [DUR_W-1:0] r_dur_cnt;

  logic              w_rise1, w_rise2;
  logic [0:0]        w_state_next;
  logic [1:0]        w_tone_next;
  logic [DUR_W-1:0]  w_dur_next;
  logic              w_load;
  logic              w_clear;
  logic [HALF_W-1:0] w_half;
  logic              w_square;

  // Previous levels reset high so an input held across reset release is not an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev1 <= 1'b1;
      r_prev2 <= 1'b1;
    end else begin
      r_prev1 <= play_sound1;
      r_prev2 <= play_sound2;
    end
  end

  assign w_rise1 = play_sound1 & ~r_prev1;
  assign w_rise2 = play_sound2 & ~r_prev2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tone_sel <= TONE_NONE;
      r_dur_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_tone_sel <= w_tone_next;
      r_dur_cnt  <= w_dur_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_tone_next  = r_tone_sel;
    w_dur_next   = r_dur_cnt;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise2) begin
          w_state_next = ST_PLAY;
          w_tone_next  = TONE_PADDLE;
          w_load       = 1'b1;
        end else if (w_rise1) begin
          w_state_next = ST_PLAY;
          w_tone_next  = TONE_HIT;
          w_load       = 1'b1;
        end
      end
      ST_PLAY: begin
        // A retrigger takes precedence over the final cycle of the tone.
        if (w_rise2) begin
          w_tone_next = TONE_PADDLE;
          w_load      = 1'b1;
        end else if (w_rise1 && (r_tone_sel == TONE_HIT)) begin
          w_load = 1'b1;
        end else if (r_dur_cnt == '0) begin
          w_state_next = ST_IDLE;
          w_tone_next  = TONE_NONE;
        end else begin
          w_dur_next = r_dur_cnt - c_dur_one;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tone_next  = TONE_NONE;
      end
    endcase
    if (w_load) begin
      w_dur_next = c_dur_load;
    end
  end

  always_comb begin
    busy     = (r_state == ST_PLAY);
    tone_sel = r_tone_sel;
    w_clear  = ~((r_state == ST_PLAY) && !w_load && (r_dur_cnt != '0));
    w_half   = (r_tone_sel == TONE_PADDLE) ? c_half2 : c_half1;
    speaker  = w_square & ~mute;
  end

  tone_div #(
    .HALF_W(HALF_W)
  ) u_tone_div (
    .clk        (clk),
    .reset      (reset),
    .clear      (w_clear),
    .half_period(w_half),
    .square     (w_square)
  );

endmodule
`default_nettype wire

// File: tb/tb_sound_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sound_gen: directed scoreboard bench for sound_gen.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_sound_gen;

  localparam int T1 = 4;
  localparam int T2 = 2;
  localparam int DUR = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       play_sound1;
  logic       play_sound2;
  logic       mute;
  logic       speaker;
  logic       busy;
  logic [1:0] tone_sel;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       busy;
    logic [1:0] tone;
    logic       spk;
    string      tag;
  } exp_t;

  exp_t sb[$];

  sound_gen #(
    .TONE1_HALF(T1),
    .TONE2_HALF(T2),
    .DURATION  (DUR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .play_sound1(play_sound1),
    .play_sound2(play_sound2),
    .mute       (mute),
    .speaker    (speaker),
    .busy       (busy),
    .tone_sel   (tone_sel)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic eb, input logic [1:0] et, input logic es, input string tag);
    exp_t e;
    e.busy = eb;
    e.tone = et;
    e.spk  = es;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_checks++;
    assert (busy === e.busy) else begin
      n_errors++;
      $error("FAIL %s busy: observed %0b expected %0b", e.tag, busy, e.busy);
    end
    n_checks++;
    assert (tone_sel === e.tone) else begin
      n_errors++;
      $error("FAIL %s tone_sel: observed %0d expected %0d", e.tag, tone_sel, e.tone);
    end
    n_checks++;
    assert (speaker === e.spk) else begin
      n_errors++;
      $error("FAIL %s speaker: observed %0b expected %0b", e.tag, speaker, e.spk);
    end
  endtask

  // k counts cycles since tone (re)start; speaker is high in odd half-periods.
  task automatic play(input logic [1:0] tone, input int half, input int k0, input int n,
                      input logic muted, input string tag);
    for (int i = 0; i < n; i++) begin
      int k;
      k = k0 + i;
      tick(1'b1, tone, (((k / half) % 2) == 1) && !muted, tag);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(1'b0, 2'd0, 1'b0, tag);
  endtask

  initial begin
    reset = 1'b1; play_sound1 = 1'b0; play_sound2 = 1'b0; mute = 1'b0;
    idle(2, "reset");
    reset = 1'b0;
    idle(2, "post_reset");

    // Single tone-1 pulse
    play_sound1 = 1'b1; play(2'd1, T1, 0, 1, 1'b0, "t1_pulse");
    play_sound1 = 1'b0; play(2'd1, T1, 1, DUR - 1, 1'b0, "t1_pulse");
    idle(3, "t1_end");

    // Tone-2 level held for 100 cycles
    play_sound2 = 1'b1; play(2'd2, T2, 0, DUR, 1'b0, "t2_held");
    idle(100 - DUR, "t2_held_no_retrig");
    play_sound2 = 1'b0; idle(2, "t2_release");

    // Tone-1 retriggered by rise1 at cycle 10
    play_sound1 = 1'b1; play(2'd1, T1, 0, 1, 1'b0, "t1_retrig");
    play_sound1 = 1'b0; play(2'd1, T1, 1, 9, 1'b0, "t1_retrig");
    play_sound1 = 1'b1; play(2'd1, T1, 0, 1, 1'b0, "t1_retrig2");
    play_sound1 = 1'b0; play(2'd1, T1, 1, DUR - 1, 1'b0, "t1_retrig2");
    idle(2, "t1_retrig_end");

    // rise1 during tone 2 is ignored
    play_sound2 = 1'b1; play(2'd2, T2, 0, 1, 1'b0, "t2_ign1");
    play_sound2 = 1'b0; play(2'd2, T2, 1, 9, 1'b0, "t2_ign1");
    play_sound1 = 1'b1; play(2'd2, T2, 10, 1, 1'b0, "t2_ign1_evt");
    play_sound1 = 1'b0; play(2'd2, T2, 11, DUR - 11, 1'b0, "t2_ign1");
    idle(2, "t2_ign1_end");

    // rise2 preempts tone 1 at cycle 10
    play_sound1 = 1'b1; play(2'd1, T1, 0, 1, 1'b0, "preempt_t1");
    play_sound1 = 1'b0; play(2'd1, T1, 1, 9, 1'b0, "preempt_t1");
    play_sound2 = 1'b1; play(2'd2, T2, 0, 1, 1'b0, "preempt_t2");
    play_sound2 = 1'b0; play(2'd2, T2, 1, DUR - 1, 1'b0, "preempt_t2");
    idle(2, "preempt_end");

    // Simultaneous rises in IDLE select tone 2
    play_sound1 = 1'b1; play_sound2 = 1'b1; play(2'd2, T2, 0, 1, 1'b0, "simul");
    play_sound1 = 1'b0; play_sound2 = 1'b0; play(2'd2, T2, 1, DUR - 1, 1'b0, "simul");
    idle(2, "simul_end");

    // Mute forces speaker low but timing is unchanged
    mute = 1'b1;
    play_sound1 = 1'b1; play(2'd1, T1, 0, 1, 1'b1, "mute");
    play_sound1 = 1'b0; play(2'd1, T1, 1, DUR - 1, 1'b1, "mute");
    idle(2, "mute_end");
    mute = 1'b0;

    // Retrigger on the last cycle of a tone keeps it playing
    play_sound1 = 1'b1; play(2'd1, T1, 0, 1, 1'b0, "last_retrig");
    play_sound1 = 1'b0; play(2'd1, T1, 1, DUR - 1, 1'b0, "last_retrig");
    play_sound1 = 1'b1; play(2'd1, T1, 0, 1, 1'b0, "last_retrig2");
    play_sound1 = 1'b0; play(2'd1, T1, 1, DUR - 1, 1'b0, "last_retrig2");
    idle(2, "last_retrig_end");

    // Reset mid-tone, with play_sound1 held high across release
    play_sound1 = 1'b1; play(2'd1, T1, 0, 1, 1'b0, "mid_reset");
    play_sound1 = 1'b0; play(2'd1, T1, 1, 14, 1'b0, "mid_reset");
    reset = 1'b1; play_sound1 = 1'b1; idle(1, "mid_reset_hit");
    reset = 1'b0; idle(3, "held_across_reset");
    play_sound1 = 1'b0; idle(1, "held_release");
    play_sound1 = 1'b1; play(2'd1, T1, 0, 1, 1'b0, "after_reset");
    play_sound1 = 1'b0; play(2'd1, T1, 1, DUR - 1, 1'b0, "after_reset");
    idle(2, "after_reset_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sound_gen.md
Name: sound_gen

Overview:
- Downstream consumer of the ball block's sound event outputs (play_sound1 for brick/wall hits, play_sound2 for paddle hits).
- Converts these event pulses or levels into a fixed-duration square-wave tone on a single speaker pin.
- Two tones with fixed priority; new events retrigger the current tone.
- Runs on the same clk as the ball logic; all inputs are synchronous to clk.

Parameters:
- TONE1_HALF, 28409, half-period in clk cycles of tone 1 (hit tone, ~440 Hz at 25 MHz); must be ≥2.
- TONE2_HALF, 14205, half-period in clk cycles of tone 2 (paddle tone, ~880 Hz); must be ≥2.
- DURATION, 1250000, tone length in clk cycles (50 ms at 25 MHz); must be ≥2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- play_sound1  in  1  hit event from ball block; may be held high for multiple cycles
- play_sound2  in  1  paddle event from ball block; may be held high for multiple cycles
- mute  in  1  when high, forces speaker low; timing continues unaffected
- speaker  out  1  square-wave output
- busy  out  1  high while a tone is playing
- tone_sel  out  2  0 = none, 1 = tone 1, 2 = tone 2

Behaviour:
- Edge detect: prev1 and prev2 registers capture play_sound1/2 each cycle.
  - rise_n = play_sound_n & ~prev_n.
  - prev1 and prev2 reset to 1, so an input held high across reset release produces no tone.
- States: IDLE and PLAY. Reset gives IDLE, busy=0, tone_sel=0, speaker=0, dur_cnt=0, half_cnt=0.
- IDLE:
  - rise2 enters PLAY with tone_sel=2; rise2 has priority when it coincides with rise1.
  - rise1 alone enters PLAY with tone_sel=1.
  - Latency: a rising edge sampled at edge n gives busy=1 after edge n.
- PLAY entry and retrigger:
  - dur_cnt loads DURATION-1, half_cnt loads 0, speaker_q loads 0.
- PLAY each cycle without a retrigger:
  - half_cnt == HALF(tone_sel)-1: toggle speaker_q and clear half_cnt; otherwise increment half_cnt.
  - dur_cnt == 0: go to IDLE, busy=0, tone_sel=0, speaker_q=0.
  - Otherwise decrement dur_cnt.
  - Resulting PLAY length is exactly DURATION cycles; the first speaker rise occurs HALF cycles after entry.
- Retrigger rules in PLAY:
  - rise2 always retriggers with tone_sel=2, including while tone 1 plays (preemption).
  - rise1 retriggers only when tone_sel=1; rise1 during tone 2 is ignored.
  - Simultaneous rise1 and rise2 behaves as rise2.
  - A retrigger arriving in the same cycle as dur_cnt==0 wins: the block stays in PLAY with counters reloaded.
- speaker = speaker_q & ~mute. This is the only combinational output path.
- busy and tone_sel are registered.
- Counter widths are $clog2 of the maximum of the relevant parameters. No wrap is possible, since counters are reloaded before overflow.
- reset has priority over every event on the same edge and returns the block to IDLE immediately, including mid-tone.

Decomposition:
- breakout_pkg (shared):
  - tone_sel encoding constants TONE_NONE=0, TONE_HIT=1, TONE_PADDLE=2.
  - Default clock-frequency constant, shared with the VGA and ball logic.
- One sub-module, tone_div:
  - Inputs: clk, reset, clear, half_period.
  - Output: square.
  - Contains half_cnt and the toggle flop.
- sound_gen holds the edge detect, the state machine and the duration counter.

Test Plan (TONE1_HALF=4, TONE2_HALF=2, DURATION=32):
- Single play_sound1 pulse after reset → busy high 32 cycles starting the next edge, tone_sel=1; speaker gives 4 full periods of 8 cycles, first rise 4 cycles after busy; then speaker=0, busy=0.
- play_sound2 held high for 100 cycles → exactly one tone of 32 cycles with tone_sel=2 and speaker period 4; no retrigger while the level stays high.
- rise1 at cycle 10 of a tone-1 tone → busy extends to 42 cycles total with the phase restarted; rise1 at cycle 10 of a tone-2 tone → ignored, busy ends at 32.
- rise2 at cycle 10 of tone 1 → tone_sel switches to 2 the next cycle; 32 more cycles of period-4 wave.
- Simultaneous rise1 and rise2 in IDLE → tone_sel=2; separately, mute high throughout → speaker stays 0 while busy and tone_sel behave identically.
- reset asserted at cycle 15 of a tone → the next edge gives busy=0, tone_sel=0, speaker=0; play_sound1 held high across reset release → no tone until it falls and rises again.
